// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch stage.
package fetch_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;
  localparam int PC_STEP  = ILEN_DEF / 8;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fetch_entry_t;

  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Memory request/response, redirect and decode-side handshake bundle of the fetch stage.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
);
  logic            redir_vld;
  logic [XLEN-1:0] redir_pc;
  logic            mem_req_vld;
  logic            mem_req_rdy;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rsp_vld;
  logic [ILEN-1:0] mem_dat_out;
  logic            id_vld;
  logic            id_rdy;
  logic [ILEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;

  modport master (
    input  redir_vld, redir_pc, mem_req_rdy, mem_rsp_vld, mem_dat_out, id_rdy,
    output mem_req_vld, mem_addr, id_vld, id_inst, id_pc
  );

  modport slave (
    output redir_vld, redir_pc, mem_req_rdy, mem_rsp_vld, mem_dat_out, id_rdy,
    input  mem_req_vld, mem_addr, id_vld, id_inst, id_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous flush; DEPTH must be a power of 2.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [cntWidth(DEPTH)-1:0] count_o
);
  localparam int CW = cntWidth(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (doPop) rdPtr_q <= rdPtr_q + PW'(1);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: PC, credit-limited memory requests, in-flight PC FIFO and fetch queue.
// Define FETCH_ALIGN_CHK_EN to flag misaligned redirects on fetch_err instead of masking them.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic    fetch_err
`endif
);
  localparam int CW   = cntWidth(FQ_DEPTH);
  localparam int STEP = ILEN / 8;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            started_q;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d;
  logic [CW-1:0]   fqCnt, ifCnt;
  logic [CW:0]     used;
  logic [XLEN-1:0] ifHead, redirTarget;
  logic            reqFire, rspOk, rspKeep, deq, halt;
  fetch_entry_t    fqIn, fqOut;

`ifdef FETCH_ALIGN_CHK_EN
  logic fetchErr_q;
  logic misaligned;

  assign misaligned  = (bus.redir_pc & XLEN'(STEP - 1)) != '0;
  assign redirTarget = bus.redir_pc;
  assign halt        = fetchErr_q;
  assign fetch_err   = fetchErr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetchErr_q <= 1'b0;
    else if (bus.redir_vld) fetchErr_q <= misaligned;
  end
`else
  assign redirTarget = bus.redir_pc & ~XLEN'(STEP - 1);
  assign halt        = 1'b0;
`endif

  // outst counts every request not yet answered, including ones marked for discard.
  assign used            = {1'b0, outst_q} + {1'b0, fqCnt};
  assign bus.mem_req_vld = started_q && !bus.redir_vld && !halt && (used < (CW+1)'(FQ_DEPTH));
  assign bus.mem_addr    = pc_q;
  assign reqFire         = bus.mem_req_vld && bus.mem_req_rdy;
  assign rspOk           = bus.mem_rsp_vld && (outst_q != '0);
  assign rspKeep         = rspOk && !bus.redir_vld && (drop_q == '0) && (ifCnt != '0);
  assign deq             = bus.id_vld && bus.id_rdy;

  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(reqFire) - CW'(rspOk);
    if (reqFire) pc_d = pc_q + XLEN'(STEP);
    if (bus.redir_vld) begin
      pc_d   = redirTarget;
      drop_d = outst_d;
    end else if (rspOk && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_inflight (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redir_vld),
    .push_i  (reqFire),
    .data_i  (pc_q),
    .pop_i   (rspKeep),
    .data_o  (ifHead),
    .count_o (ifCnt)
  );

  assign fqIn.pc   = ifHead;
  assign fqIn.inst = bus.mem_dat_out;

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_fq (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.redir_vld),
    .push_i  (rspKeep),
    .data_i  (fqIn),
    .pop_i   (deq),
    .data_o  (fqOut),
    .count_o (fqCnt)
  );

  assign bus.id_vld  = fqCnt != '0;
  assign bus.id_inst = fqOut.inst;
  assign bus.id_pc   = fqOut.pc;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised, decoupled instruction-fetch stage, the successor to the single-cycle fetch path. Owns the program counter, issues pipelined in-order requests to instruction memory through a valid/ready handshake, and buffers returned instructions with their PCs in a fetch queue feeding decode. Supports redirects (branch/jump/exception) with flush of queued and in-flight instructions, and back-pressure from decode.

## Interface
- XLEN, 32, PC/address width
- ILEN, 32, instruction width; ILEN/8 is the PC step
- RESET_PC, 32'h0000_0000, PC after reset
- FQ_DEPTH, 4, fetch-queue entries and maximum in-flight requests; power of 2, ≥2
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- redir_vld  in  1  redirect request
- redir_pc  in  XLEN  redirect target
- mem_req_vld  out  1  request valid
- mem_req_rdy  in  1  memory accepts request
- mem_addr  out  XLEN  request address (= current PC)
- mem_rsp_vld  in  1  response valid; in order; no back-pressure
- mem_dat_out  in  ILEN  response data
- id_vld  out  1  decode-side instruction valid
- id_rdy  in  1  decode accepts instruction
- id_inst  out  ILEN  instruction to decode
- id_pc  out  XLEN  PC of id_inst

## Operation
- Request fires when mem_req_vld && mem_req_rdy: PC of the request is pushed to the in-flight PC FIFO; pc <= pc + ILEN/8, wrapping modulo 2^XLEN.
- Credit: mem_req_vld = started && !redir_vld && (outst + fq_cnt < FQ_DEPTH). outst and fq_cnt are registered, so a dequeue frees its credit the next cycle.
- Response (mem_rsp_vld, drop_cnt==0): pop the in-flight PC and write {pc, mem_dat_out} to the fetch queue. Credits guarantee the queue never overflows.
- mem_rsp_vld with outst==0 is a protocol violation; the response is ignored.
- Dequeue when id_vld && id_rdy. id_* come from registered queue-head storage.
- Redirect (redir_vld high in cycle t): flush the fetch queue and the in-flight PC FIFO; pc <= redir_pc; drop_cnt <= outstanding requests not returned in t; no request in t. A response in t is discarded.
- Discard: while drop_cnt>0, each mem_rsp_vld decrements drop_cnt and nothing is written. Discarded requests still hold credits until they return.
- Redirect while drop_cnt>0 adds the new in-flight count to the remaining drop_cnt.
- Simultaneous request, response and dequeue in one cycle are all honoured.

## Timing
- Reset values: pc=RESET_PC, mem_addr=RESET_PC, mem_req_vld=0, started=0, outst=0, drop_cnt=0, fq empty, id_vld=0, id_inst=0, id_pc=0.
- started sets on the first clk after rst_n deasserts; the first request is offered in that cycle +1.
- Request accepted in cycle t and answered in cycle t+L (L≥1): id_vld is high from t+L+1.
- Back-to-back accepted requests with L=1 and id_rdy=1 give one instruction per cycle.
- Redirect in t: id_vld=0 at t+1; mem_addr=redir_pc with mem_req_vld (if credit) at t+1.
- rst_n asserted mid-operation: all state returns to reset values immediately. Responses from before reset are the memory's responsibility and are not dropped.

## Configuration
- FETCH_ALIGN_CHK_EN defined:
  - Adds output fetch_err (1 bit, reset 0).
  - A redirect whose low log2(ILEN/8) bits are non-zero sets fetch_err, still flushes, and halts requests (mem_req_vld=0).
  - The next aligned redirect clears fetch_err and resumes fetching.
- FETCH_ALIGN_CHK_EN undefined: no fetch_err port; the low bits of redir_pc are forced to zero.

## Structure
- Package fetch_pkg:
  - fetch_entry_t struct {pc, inst}.
  - Constant for the PC step, ILEN/8.
  - Helper function for the counter width, $clog2(FQ_DEPTH+1).
- Sub-module fetch_fifo: generic synchronous FIFO with parametrised width and depth, count output and synchronous flush. Instantiated twice: once for the in-flight PCs (XLEN wide) and once for the fetch queue (fetch_entry_t).

## Test plan
- Reset release, mem_req_rdy=1, 1-cycle response memory, id_rdy=1:
  - addresses 0x0, 0x4, 0x8… on consecutive cycles;
  - id_pc/id_inst stream matches with 1 instruction per cycle after 3 cycles.
- id_rdy=0, FQ_DEPTH=4: exactly 4 requests issued, then mem_req_vld=0. Raise id_rdy: 4 instructions drain in order and fetching resumes.
- Redirect to 0x100 with 3 requests in flight (latency 3): those 3 responses are dropped, id_pc starts at 0x100 and no stale instruction appears.
- mem_req_rdy toggling randomly: no address is skipped or repeated, and the PC advances only on accepted requests.
- PC at 0xFFFF_FFFC: the next request address is 0x0000_0000.
- With FETCH_ALIGN_CHK_EN, redirect to 0x102:
  - fetch_err=1 and mem_req_vld=0;
  - a redirect to 0x200 clears fetch_err and the next mem_addr is 0x200.
